id_stage: RTL and testbench

Instruction-decode stage of the 19-bit pipelined CPU. It sits between the IF/ID pipeline register and the ID/EX register, and has three jobs: decode the 19-bit instruction into the control bundle and operand fields that ID/EX latches, read and write the 8×19-bit register file, and detect load-use hazards. On a hazard it stalls the front end and injects a bubble; on a flush it squashes the decoded instruction. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/id_stage.sv | 141 ++++++++++++++
 tb/tb_id_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode for the 19-bit pipeline: control decode, 8x19 register file
// with write-through bypass, load-use hazard detection and a stall-cycle counter.
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   if_instr, if_valid         instruction from IF/ID
//   flush                      squash the instruction in ID
//   ex_memread, ex_wdest       load in EX and its destination register
//   wb_regwrite, wb_rd, wb_data  register write-back
//   id_*                       decoded fields, controls and operands to ID/EX
//   id_stall                   hold PC and IF/ID this cycle
//   id_illegal                 valid instruction with undefined opcode
//   stall_count                saturating stall-cycle counter
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] if_instr,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [2:0]  ex_wdest,
    input  logic        wb_regwrite,
    input  logic [2:0]  wb_rd,
    input  logic [18:0] wb_data,
    output logic [4:0]  id_opcode,
    output logic        id_regwrite,
    output logic        id_memtoreg,
    output logic        id_memread,
    output logic        id_memwrite,
    output logic        id_alusrc,
    output logic        id_aluop,
    output logic        id_regdist,
    output logic [7:0]  id_immediate,
    output logic [2:0]  id_rs,
    output logic [2:0]  id_rt,
    output logic [2:0]  id_rd,
    output logic [18:0] id_rd1,
    output logic [18:0] id_rd2,
    output logic        id_stall,
    output logic        id_illegal,
    output logic [15:0] stall_count
);

    logic [18:0] regs [8];

    logic       is_nop, is_r, is_addi, is_ld, is_st, is_ill;
    logic [6:0] ctl;
    logic       use1, use2;
    logic [2:0] ra2;
    logic       bubble;

    assign id_opcode    = if_instr[18:14];
    assign id_rd        = if_instr[13:11];
    assign id_rs        = if_instr[10:8];
    assign id_rt        = if_instr[7:5];
    assign id_immediate = if_instr[7:0];

    assign is_nop  = (id_opcode == 5'h00);
    assign is_r    = (id_opcode >= 5'h01) && (id_opcode <= 5'h05);
    assign is_addi = (id_opcode == 5'h06);
    assign is_ld   = (id_opcode == 5'h07);
    assign is_st   = (id_opcode == 5'h08);
    assign is_ill  = (id_opcode >= 5'h09);

    // ctl = {regwrite, memtoreg, memread, memwrite, alusrc, aluop, regdist}
    always_comb begin
        ctl  = 7'b0;
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (1'b1)
            is_r: begin
                ctl  = 7'b1000011;
                use1 = 1'b1;
                use2 = 1'b1;
            end
            is_addi: begin
                ctl  = 7'b1000111;
                use1 = 1'b1;
            end
            is_ld: begin
                ctl  = 7'b1110101;
                use1 = 1'b1;
            end
            is_st: begin
                ctl  = 7'b0001100;
                use1 = 1'b1;
                use2 = 1'b1;
            end
            is_nop, is_ill: begin
                ctl  = 7'b0;
            end
        endcase
    end

    // Stores read their data register through port 2.
    assign ra2 = is_st ? id_rd : id_rt;

    assign id_stall = rst_n && if_valid && !flush && ex_memread
                   && (ex_wdest != 3'd0)
                   && ((use1 && (ex_wdest == id_rs))
                    || (use2 && (ex_wdest == ra2)));

    assign bubble = id_stall || flush || !if_valid || !rst_n;

    assign {id_regwrite, id_memtoreg, id_memread, id_memwrite,
            id_alusrc, id_aluop, id_regdist} = bubble ? 7'b0 : ctl;

    assign id_illegal = rst_n && if_valid && is_ill;

    // r0 is never written, so it reads its reset value of zero.
    always_comb begin
        id_rd1 = '0;
        id_rd2 = '0;
        if (rst_n) begin
            if (wb_regwrite && (wb_rd != 3'd0) && (wb_rd == id_rs))
                id_rd1 = wb_data;
            else
                id_rd1 = regs[id_rs];
            if (wb_regwrite && (wb_rd != 3'd0) && (wb_rd == ra2))
                id_rd2 = wb_data;
            else
                id_rd2 = regs[ra2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else if (wb_regwrite && (wb_rd != 3'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (id_stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage.
// Drives inputs just after rising edges and checks combinational outputs before the next.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [18:0] if_instr;
    logic        if_valid;
    logic        flush;
    logic        ex_memread;
    logic [2:0]  ex_wdest;
    logic        wb_regwrite;
    logic [2:0]  wb_rd;
    logic [18:0] wb_data;
    logic [4:0]  id_opcode;
    logic        id_regwrite, id_memtoreg, id_memread, id_memwrite;
    logic        id_alusrc, id_aluop, id_regdist;
    logic [7:0]  id_immediate;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic [18:0] id_rd1, id_rd2;
    logic        id_stall, id_illegal;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_instr(if_instr), .if_valid(if_valid), .flush(flush),
        .ex_memread(ex_memread), .ex_wdest(ex_wdest),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_opcode(id_opcode),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regdist(id_regdist),
        .id_immediate(id_immediate),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_stall(id_stall), .id_illegal(id_illegal),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] enc(input logic [4:0] op,
                                        input logic [2:0] rd,
                                        input logic [2:0] rs,
                                        input logic [2:0] rt,
                                        input logic [4:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    function automatic logic [6:0] ctl();
        return {id_regwrite, id_memtoreg, id_memread, id_memwrite,
                id_alusrc, id_aluop, id_regdist};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        if_instr    = enc(5'h01, 3'd1, 3'd3, 3'd3, 5'd0);
        if_valid    = 1'b1;
        flush       = 1'b0;
        ex_memread  = 1'b1;
        ex_wdest    = 3'd3;
        wb_regwrite = 1'b1;
        wb_rd       = 3'd3;
        wb_data     = 19'h7ABCD;
        #2;
        chk("rst_rd1", id_rd1, 0);
        chk("rst_ctl", ctl(), 0);
        chk("rst_stall", id_stall, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_opcode", id_opcode, 5'h01);

        // Release reset mid-cycle; the write of r3 commits at the next edge.
        ex_memread = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("bypass_r3", id_rd1, 19'h7ABCD);
        edge1();
        wb_regwrite = 1'b0;
        #1;
        chk("add_rd1", id_rd1, 19'h7ABCD);
        chk("add_rd2", id_rd2, 19'h7ABCD);
        chk("add_ctl", ctl(), 7'b1000011);
        chk("add_rd", id_rd, 3'd1);

        // Same-cycle bypass into ADDI rs=5, imm=0x2A.
        edge1();
        if_instr    = enc(5'h06, 3'd0, 3'd5, 3'd1, 5'h0A);
        wb_regwrite = 1'b1;
        wb_rd       = 3'd5;
        wb_data     = 19'h12345;
        #1;
        chk("addi_rd1", id_rd1, 19'h12345);
        chk("addi_imm", id_immediate, 8'h2A);
        chk("addi_ctl", ctl(), 7'b1000111);
        chk("addi_rd2", id_rd2, 0);

        // Write to r0 is ignored and not bypassed.
        edge1();
        if_instr = enc(5'h01, 3'd2, 3'd0, 3'd5, 5'd0);
        wb_rd    = 3'd0;
        wb_data  = 19'h00001;
        #1;
        chk("r0_bypass", id_rd1, 0);
        chk("r5_array", id_rd2, 19'h12345);
        edge1();
        wb_regwrite = 1'b0;
        #1;
        chk("r0_after", id_rd1, 0);

        // Load-use on rs of ADD.
        ex_memread = 1'b1;
        ex_wdest   = 3'd2;
        if_instr   = enc(5'h01, 3'd1, 3'd2, 3'd0, 5'd0);
        #1;
        chk("lu_add_stall", id_stall, 1);
        chk("lu_add_ctl", ctl(), 0);
        edge1();
        chk("lu_cnt1", stall_count, 16'd1);
        if_instr = enc(5'h06, 3'd0, 3'd0, 3'd2, 5'd0);
        #1;
        chk("lu_addi_stall", id_stall, 0);
        chk("lu_addi_ctl", ctl(), 7'b1000111);
        if_instr = enc(5'h07, 3'd4, 3'd1, 3'd2, 5'd0);
        #1;
        chk("ld_stall", id_stall, 0);
        chk("ld_ctl", ctl(), 7'b1110101);

        // Store reads rd through port 2.
        ex_wdest = 3'd4;
        if_instr = enc(5'h08, 3'd4, 3'd0, 3'd0, 5'd0);
        #1;
        chk("st_stall", id_stall, 1);
        chk("st_rd2", id_rd2, 0);
        edge1();
        chk("st_cnt2", stall_count, 16'd2);
        flush = 1'b1;
        #1;
        chk("st_flush_stall", id_stall, 0);
        chk("st_flush_ctl", ctl(), 0);
        flush      = 1'b0;
        ex_memread = 1'b0;
        if_instr   = enc(5'h08, 3'd5, 3'd3, 3'd0, 5'd0);
        #1;
        chk("st_ctl", ctl(), 7'b0001100);
        chk("st_data", id_rd2, 19'h12345);
        chk("st_base", id_rd1, 19'h7ABCD);

        // Illegal opcode.
        if_instr = enc(5'h1F, 3'd0, 3'd0, 3'd0, 5'd0);
        #1;
        chk("ill_flag", id_illegal, 1);
        chk("ill_ctl", ctl(), 0);
        if_valid = 1'b0;
        #1;
        chk("ill_invalid", id_illegal, 0);
        if_valid = 1'b1;
        if_instr = enc(5'h01, 3'd1, 3'd2, 3'd3, 5'd0);
        if_valid = 1'b0;
        #1;
        chk("invalid_ctl", ctl(), 0);
        if_valid = 1'b1;

        // Saturate the stall counter.
        ex_memread = 1'b1;
        ex_wdest   = 3'd2;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", stall_count, 16'hFFFF);
        edge1();
        chk("sat_hold", stall_count, 16'hFFFF);

        // Asynchronous reset mid-run.
        if_instr = enc(5'h01, 3'd1, 3'd3, 3'd2, 5'd0);
        #1;
        chk("pre_rst_stall", id_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_cnt", stall_count, 0);
        chk("mrst_stall", id_stall, 0);
        chk("mrst_rd1", id_rd1, 0);
        chk("mrst_ctl", ctl(), 0);

        // Write during reset is discarded.
        ex_memread  = 1'b0;
        wb_regwrite = 1'b1;
        wb_rd       = 3'd3;
        wb_data     = 19'h55555;
        edge1();
        wb_regwrite = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_r3", id_rd1, 0);
        if_instr = enc(5'h01, 3'd1, 3'd5, 3'd0, 5'd0);
        #1;
        chk("post_rst_r5", id_rd1, 0);
        chk("post_rst_ctl", ctl(), 7'b1000011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
